radix4_butterfly_pipe: RTL
==========================

// Module: radix4_butterfly_pipe
// PURPOSE
//   Pipelined, parametrised radix-4 DIT butterfly for the FFT datapath.
//   Twiddles arrive per beat on ports, not as fixed constants, so one instance serves every stage/group.
//   Adds valid/ready flow control, optional per-beat divide-by-4 scaling, rounding, saturation and an overflow flag.
//   Sits between the stage input buffer and the stage output buffer.
// PARAMETERS
//   DW    16  sample and twiddle width, two's complement
//   FRAC  14  twiddle fractional bits (Q2.14 at default; 1.0 = 0x4000)
// PORTS
//   clk        in   1     clock; all state on rising edge
//   rst_n      in   1     reset, asynchronous assert, active-low
//   in_valid   in   1     input beat valid
//   in_ready   out  1     block can accept a beat
//   scale_en   in   1     1: divide outputs by 4 (sampled with beat)
//   a_re,a_im  in   DW    input A (untwiddled)
//   b_re..d_im in   DW    inputs B,C,D (6 ports)
//   w1_re..w3_im in DW    twiddles W1,W2,W3 applied to B,C,D (6 ports)
//   out_valid  out  1     output beat valid
//   out_ready  in   1     downstream accepts beat
//   y0_re..y3_im out DW   four complex outputs (8 ports)
//   ovf        out  1     saturation occurred on this output beat
// BEHAVIOUR
//   Reset: out_valid=0, ovf=0, all y*=0, internal stage valids=0.
//     Takes effect immediately, mid-stream included; in-flight beats are discarded.
//   Pipeline: 3 register stages. en = !out_valid | out_ready; in_ready = en (combinational).
//   Handshake:
//     - Beat accepted when in_valid & in_ready.
//     - With no stall, out_valid rises 3 cycles after acceptance.
//     - When en=0, every stage holds; no beat is lost, duplicated or reordered.
//     - Bubbles are not compressed.
//     - Outputs are stable while out_valid & !out_ready.
//   S1: register A..D, W1..W3, scale_en.
//   S2: complex products X1=B*W1, X2=C*W2, X3=D*W3.
//     - re = (Pr*Wr - Pi*Wi + 2^(FRAC-1)) >>> FRAC; im likewise with Pr*Wi + Pi*Wr.
//     - Full precision before the shift; result kept as DW+2 bits.
//     - Any multiplier decomposition (e.g. 3-mult form) is allowed; results must be bit-exact to this rule.
//   S3: y_k = A + sum_m (-j)^(k*m) * X_m, for k = 0..3, m = 1..3:
//     y0 = A+X1+X2+X3
//     y1 = A-jX1-X2+jX3
//     y2 = A-X1+X2-X3
//     y3 = A+jX1-X2-jX3
//     - (-j)(xr+jxi) = xi - j*xr.
//     - Sums are formed in DW+4 bits.
//     - If scale_en: v = (v + 2) >>> 2.
//     - Then saturate to [-2^(DW-1), 2^(DW-1)-1].
//     - ovf = OR of saturation over all 8 components; valid only with out_valid.
//   Twiddle magnitude up to 2.0 is legal; -2.0 (0x8000) is legal and has no special case.
// TESTING
//   1) A=(0x1000,0), B=C=D=0, any W, scale_en=0 -> all y=(0x1000,0), ovf=0; with scale_en=1 -> all y=(0x0400,0).
//   2) B=(0x1000,0), A=C=D=0, W1=(0x4000,0) -> y0=(0x1000,0), y1=(0,0xF000), y2=(0xF000,0), y3=(0,0x1000).
//   3) A=B=C=D=(0x7FFF,0), all W=(0x4000,0):
//      - scale_en=0 -> y0=(0x7FFF,0), ovf=1.
//      - scale_en=1 -> y0=(0x7FFF,0), ovf=0, and y1=y2=y3=(0,0).
//   4) Rounding: B=(0x0001,0), W1=(0x2000,0): B*W1=0x2000 and 0x2000+0x2000=0x4000, so re=0x4000>>>14=1 -> y0=(1,0). Repeat with B=(0xFFFF,0) -> y0=(0,0).
//   5) Stream 8 random beats with out_ready low for cycles 4-9:
//      - in_ready low while the pipe is full.
//      - Outputs match the bit-exact model, in order, with no loss.
//      - y* held stable during the stall.
//   6) Assert rst_n low for 1 cycle with 2 beats in flight -> out_valid=0 at once, y*=0, ovf=0; those beats are never output.

Source files
------------

// File: rtl/radix4_butterfly_pipe.sv
// radix4_butterfly_pipe: 3-stage radix-4 DIT butterfly with per-beat twiddles,
// valid/ready flow control, optional /4 scaling, rounding and saturation.
module radix4_butterfly_pipe #(
    parameter int DW   = 16,
    parameter int FRAC = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          scale_en,
    input  logic [DW-1:0] a_re,
    input  logic [DW-1:0] a_im,
    input  logic [DW-1:0] b_re,
    input  logic [DW-1:0] b_im,
    input  logic [DW-1:0] c_re,
    input  logic [DW-1:0] c_im,
    input  logic [DW-1:0] d_re,
    input  logic [DW-1:0] d_im,
    input  logic [DW-1:0] w1_re,
    input  logic [DW-1:0] w1_im,
    input  logic [DW-1:0] w2_re,
    input  logic [DW-1:0] w2_im,
    input  logic [DW-1:0] w3_re,
    input  logic [DW-1:0] w3_im,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] y0_re,
    output logic [DW-1:0] y0_im,
    output logic [DW-1:0] y1_re,
    output logic [DW-1:0] y1_im,
    output logic [DW-1:0] y2_re,
    output logic [DW-1:0] y2_im,
    output logic [DW-1:0] y3_re,
    output logic [DW-1:0] y3_im,
    output logic          ovf
);
    localparam int PW = 2 * DW + 2;
    localparam int XW = DW + 2;
    localparam int SW = DW + 4;
    localparam logic signed [PW-1:0] HALF = PW'(2 ** (FRAC - 1));
    localparam logic signed [SW-1:0] MAXV = SW'(2 ** (DW - 1) - 1);
    localparam logic signed [SW-1:0] MINV = ~MAXV;

    logic                 en, v1, v2, sc1, sc2, oc;
    logic signed [DW-1:0] p1 [8];
    logic signed [DW-1:0] w1 [6];
    logic signed [DW-1:0] a2 [2];
    logic signed [XW-1:0] xc [6];
    logic signed [XW-1:0] x2 [6];
    logic signed [PW-1:0] t_re, t_im;
    logic signed [SW-1:0] e  [8];
    logic signed [SW-1:0] s  [8];
    logic signed [SW-1:0] t;
    logic signed [DW-1:0] yc [8];
    logic signed [DW-1:0] yq [8];

    assign en       = !out_valid | out_ready;
    assign in_ready = en;

    // Complex products, rounded half-up at full precision then kept as DW+2 bits
    always_comb begin
        t_re = '0;
        t_im = '0;
        for (int m = 0; m < 3; m++) begin
            t_re = PW'(p1[2+2*m]) * PW'(w1[2*m]) - PW'(p1[3+2*m]) * PW'(w1[2*m+1]) + HALF;
            t_im = PW'(p1[2+2*m]) * PW'(w1[2*m+1]) + PW'(p1[3+2*m]) * PW'(w1[2*m]) + HALF;
            xc[2*m]   = XW'(t_re >>> FRAC);
            xc[2*m+1] = XW'(t_im >>> FRAC);
        end
    end

    // e: A re/im followed by X1..X3 re/im; -j*x swaps components and negates the new imag
    always_comb begin
        e[0] = SW'(a2[0]);
        e[1] = SW'(a2[1]);
        for (int i = 0; i < 6; i++) e[i+2] = SW'(x2[i]);
        s[0] = e[0] + e[2] + e[4] + e[6];
        s[1] = e[1] + e[3] + e[5] + e[7];
        s[2] = e[0] + e[3] - e[4] - e[7];
        s[3] = e[1] - e[2] - e[5] + e[6];
        s[4] = e[0] - e[2] + e[4] - e[6];
        s[5] = e[1] - e[3] + e[5] - e[7];
        s[6] = e[0] - e[3] - e[4] + e[7];
        s[7] = e[1] + e[2] - e[5] - e[6];
        t    = '0;
        oc   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            t     = sc2 ? (s[k] + SW'(2)) >>> 2 : s[k];
            yc[k] = t > MAXV ? DW'(MAXV) : t < MINV ? DW'(MINV) : DW'(t);
            oc    = oc | (t > MAXV) | (t < MINV);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            sc1       <= 1'b0;
            sc2       <= 1'b0;
            out_valid <= 1'b0;
            ovf       <= 1'b0;
            a2[0]     <= '0;
            a2[1]     <= '0;
            for (int i = 0; i < 8; i++) begin
                p1[i] <= '0;
                yq[i] <= '0;
            end
            for (int i = 0; i < 6; i++) begin
                w1[i] <= '0;
                x2[i] <= '0;
            end
        end else if (en) begin
            v1        <= in_valid;
            sc1       <= scale_en;
            p1[0]     <= a_re;
            p1[1]     <= a_im;
            p1[2]     <= b_re;
            p1[3]     <= b_im;
            p1[4]     <= c_re;
            p1[5]     <= c_im;
            p1[6]     <= d_re;
            p1[7]     <= d_im;
            w1[0]     <= w1_re;
            w1[1]     <= w1_im;
            w1[2]     <= w2_re;
            w1[3]     <= w2_im;
            w1[4]     <= w3_re;
            w1[5]     <= w3_im;
            v2        <= v1;
            sc2       <= sc1;
            a2[0]     <= p1[0];
            a2[1]     <= p1[1];
            x2        <= xc;
            out_valid <= v2;
            yq        <= yc;
            ovf       <= oc;
        end
    end

    assign y0_re = yq[0];
    assign y0_im = yq[1];
    assign y1_re = yq[2];
    assign y1_im = yq[3];
    assign y2_re = yq[4];
    assign y2_im = yq[5];
    assign y3_re = yq[6];
    assign y3_im = yq[7];
endmodule
